interval_timer_ctrl: RTL

//   Controller that sequences a WIDTH-bit up-counter as a programmable interval timer.

---
 rtl/interval_timer_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
//
// Programmable interval timer controller. A WIDTH-bit up-counter runs from 0 to
// a host-programmed terminal value. A prescaler paces the counter: it advances
// once every (prescale+1) clock cycles. One-shot and periodic modes are
// supported, together with start/pause/stop control and a sticky interrupt
// that the host acknowledges.
//
// Ports
//   clk            clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   start          level: begin a run from IDLE, or resume from PAUSED
//   pause          freeze counting while running
//   stop           abort to IDLE from any state (highest priority)
//   load_valid     write period/prescale/mode (accepted only while load_ready)
//   load_ready     high iff the controller is IDLE
//   load_period    terminal count value (count runs 0..period)
//   load_prescale  counter advances every (prescale+1) cycles
//   load_periodic  1 = auto-restart after expiry, 0 = one-shot
//   irq_ack        clears irq (a simultaneous expiry wins)
//   count          current count value
//   running        high iff the controller is in RUN
//   expired        one-cycle pulse per terminal count
//   irq            sticky interrupt, set on every expiry
// -----------------------------------------------------------------------------
module interval_timer_ctrl #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_period,
    input  logic [PRESCALE_W-1:0] load_prescale,
    input  logic                  load_periodic,
    input  logic                  irq_ack,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  expired,
    output logic                  irq
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [1:0]            state_q,      state_d;
    logic [WIDTH-1:0]      count_q,      count_d;
    logic [PRESCALE_W-1:0] pre_cnt_q,    pre_cnt_d;
    logic [WIDTH-1:0]      period_q,     period_d;
    logic [PRESCALE_W-1:0] prescale_q,   prescale_d;
    logic                  periodic_q,   periodic_d;
    logic                  expired_q,    expired_d;
    logic                  irq_q,        irq_d;
    logic                  running_q,    running_d;
    logic                  load_ready_q, load_ready_d;
    logic                  tick_s;
    logic                  expire_s;

    // Next-state computation: control decode, prescaler, counter and irq.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_cnt_d  = pre_cnt_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        tick_s     = 1'b0;
        expire_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Configuration is only writable here, so a run never sees
                // its parameters change underneath it.
                if (load_valid) begin
                    period_d   = load_period;
                    prescale_d = load_prescale;
                    periodic_d = load_periodic;
                end else begin
                    period_d   = period_q;
                    prescale_d = prescale_q;
                    periodic_d = periodic_q;
                end
                if (stop || pause) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d   = ST_RUN;
                    count_d   = CNT_ZERO;
                    pre_cnt_d = PRE_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // count is left visible; the prescaler phase is discarded.
                    state_d   = ST_IDLE;
                    pre_cnt_d = PRE_ZERO;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    if (pre_cnt_q == prescale_q) begin
                        pre_cnt_d = PRE_ZERO;
                        tick_s    = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PRE_ONE;
                        tick_s    = 1'b0;
                    end
                    // Wrap comes from the terminal compare, never from overflow,
                    // so an all-ones period still behaves as a full interval.
                    if (tick_s && (count_q == period_q)) begin
                        expire_s  = 1'b1;
                        expired_d = 1'b1;
                        count_d   = CNT_ZERO;
                        if (periodic_q) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (tick_s) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                end
            end

            ST_PAUSED: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    pre_cnt_d = PRE_ZERO;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (start) begin
                    // Resume with both counters untouched so the prescaler
                    // phase carries straight on.
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe idle state.
                state_d   = ST_IDLE;
                pre_cnt_d = PRE_ZERO;
            end
        endcase

        // A new expiry takes precedence over an acknowledge in the same cycle
        // so that no event is ever lost.
        if (expire_s) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        running_d    = (state_d == ST_RUN);
        load_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= CNT_ZERO;
            pre_cnt_q    <= PRE_ZERO;
            period_q     <= CNT_ZERO;
            prescale_q   <= PRE_ZERO;
            periodic_q   <= 1'b0;
            expired_q    <= 1'b0;
            irq_q        <= 1'b0;
            running_q    <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pre_cnt_q    <= pre_cnt_d;
            period_q     <= period_d;
            prescale_q   <= prescale_d;
            periodic_q   <= periodic_d;
            expired_q    <= expired_d;
            irq_q        <= irq_d;
            running_q    <= running_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign count      = count_q;
    assign running    = running_q;
    assign expired    = expired_q;
    assign irq        = irq_q;
    assign load_ready = load_ready_q;

endmodule
